// File: rtl/miner_pkg.sv
// Shared miner definitions: control word layout, result codes, scheduler states and stop causes.
package miner_pkg;
  localparam int CTL_RUN      = 0;
  localparam int CTL_TEST     = 1;
  localparam int CTL_HALT     = 2;
  localparam int CTL_PADL_LSB = 3;
  localparam int CTL_PADF_LSB = 11;

  localparam logic [7:0] PADF_DEFAULT = 8'h06;
  localparam logic [7:0] PADL_DEFAULT = 8'h80;

  localparam logic [1:0] RES_FOUND     = 2'd0;
  localparam logic [1:0] RES_EXHAUSTED = 2'd1;
  localparam logic [1:0] RES_ABORTED   = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ARM, ST_RUN, ST_HALT, ST_STOP, ST_EVAL, ST_REPORT
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_MATCH, CAUSE_CHECKPOINT, CAUSE_ABORT
  } cause_e;

  function automatic logic [18:0] ctl_word(input logic [7:0] padf, input logic [7:0] padl,
                                           input logic halt, input logic test, input logic run);
    logic [18:0] w;
    w = '0;
    w[CTL_PADF_LSB +: 8] = padf;
    w[CTL_PADL_LSB +: 8] = padl;
    w[CTL_HALT] = halt;
    w[CTL_TEST] = test;
    w[CTL_RUN]  = run;
    return w;
  endfunction

  // Offset arithmetic wraps modulo 2^64 so ranges straddling all-ones behave.
  function automatic logic nonce_in_range(input logic [63:0] cur, input logic [63:0] start,
                                          input logic [63:0] count);
    logic [63:0] offset;
    offset = cur - start;
    return offset < count;
  endfunction
endpackage

// File: rtl/miner_ctl_sync_wait.sv
// Hold counter: done once N cycles have elapsed since restart and cond is true.
// Latency N cycles minimum; cond stretches the hold indefinitely.
module miner_ctl_sync_wait
  import miner_pkg::*;
#(
  parameter int N = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic cond,
  output logic done
);
  localparam int CW = (N > 1) ? $clog2(N + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == LAST) && cond;
endmodule

// File: rtl/miner_job_scheduler.sv
// Runs one miner per host job in timeslices with halt checkpoints; result 1 cycle after EVAL.
// Backpressure: job_ready only in IDLE; result held in REPORT until res_ready.
module miner_job_scheduler
  import miner_pkg::*;
#(
  parameter int         TIMESLICE   = 4096,
  parameter int         SYNC_CYCLES = 3,
  parameter logic [7:0] PADF        = PADF_DEFAULT,
  parameter logic [7:0] PADL        = PADL_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [255:0] job_header,
  input  logic [255:0] job_difficulty,
  input  logic [63:0]  job_start_nonce,
  input  logic [63:0]  job_nonce_count,
  input  logic         job_test,
  input  logic         abort,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [63:0]  res_nonce,
  output logic [1:0]   res_code,
  output logic [255:0] miner_header,
  output logic [255:0] miner_difficulty,
  output logic [63:0]  miner_start_nonce,
  output logic [18:0]  miner_control,
  input  logic [63:0]  miner_solution,
  input  logic         miner_irq,
  output logic         busy
);
  localparam int TW = (TIMESLICE > 1) ? $clog2(TIMESLICE) : 1;
  localparam logic [TW-1:0] TS_LAST  = TW'(TIMESLICE - 1);
  localparam logic [TW-1:0] IRQ_MASK = TW'(SYNC_CYCLES);
  localparam logic [18:0]   CTL_IDLE = ctl_word(PADF, PADL, 1'b0, 1'b0, 1'b0);

  state_e         state_q, state_d;
  cause_e         cause_q, cause_d;
  logic [255:0]   hdr_q, hdr_d, diff_q, diff_d;
  logic [63:0]    start_q, start_d, count_q, count_d, cur_q, cur_d;
  logic           test_q, test_d;
  logic [TW-1:0]  ts_q, ts_d;
  logic           job_ready_q, job_ready_d, busy_q, busy_d;
  logic           res_valid_q, res_valid_d;
  logic [63:0]    res_nonce_q, res_nonce_d, mstart_q, mstart_d;
  logic [1:0]     res_code_q, res_code_d;
  logic [18:0]    ctl_q, ctl_d;
  logic           hold_restart, hold_cond, hold_done;

  // ARM and STOP both need a settle window for the miner's 2-flop control sync.
  miner_ctl_sync_wait #(.N(SYNC_CYCLES)) u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (hold_restart),
    .cond    (hold_cond),
    .done    (hold_done)
  );

  assign hold_restart = (state_d != state_q);
  assign hold_cond    = (state_q == ST_STOP) ? !miner_irq : 1'b1;

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    hdr_d      = hdr_q;
    diff_d     = diff_q;
    start_d    = start_q;
    count_d    = count_q;
    test_d     = test_q;
    cur_d      = cur_q;
    res_code_d = res_code_q;
    ts_d       = '0;
    case (state_q)
      ST_IDLE: begin
        if (job_valid && job_ready_q) begin
          hdr_d   = job_header;
          diff_d  = job_difficulty;
          start_d = job_start_nonce;
          count_d = job_nonce_count;
          test_d  = job_test;
          cur_d   = job_start_nonce;
          if (job_nonce_count == 64'd0) begin
            state_d    = ST_REPORT;
            res_code_d = RES_EXHAUSTED;
          end else begin
            state_d = ST_ARM;
          end
        end
      end
      ST_ARM: begin
        if (abort) begin
          state_d = ST_STOP;
          cause_d = CAUSE_ABORT;
        end else if (hold_done) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        ts_d = ts_q + 1'b1;
        // Early irq may be a leftover from before the miner saw run rise.
        if (abort) begin
          state_d = ST_STOP;
          cause_d = CAUSE_ABORT;
        end else if (miner_irq && (ts_q >= IRQ_MASK)) begin
          state_d = ST_STOP;
          cause_d = CAUSE_MATCH;
          cur_d   = miner_solution;
        end else if (ts_q == TS_LAST) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (abort) begin
          state_d = ST_STOP;
          cause_d = CAUSE_ABORT;
        end else if (miner_irq) begin
          state_d = ST_STOP;
          cause_d = CAUSE_CHECKPOINT;
          cur_d   = miner_solution;
        end
      end
      ST_STOP: begin
        if (hold_done) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        state_d = ST_REPORT;
        if (cause_q == CAUSE_ABORT) begin
          res_code_d = RES_ABORTED;
        end else if (!nonce_in_range(cur_q, start_q, count_q)) begin
          res_code_d = RES_EXHAUSTED;
        end else if (cause_q == CAUSE_MATCH) begin
          res_code_d = RES_FOUND;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_REPORT: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    job_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    res_valid_d = (state_d == ST_REPORT);
    res_nonce_d = res_nonce_q;
    if ((state_d == ST_REPORT) && (state_q != ST_REPORT)) res_nonce_d = cur_d;
    mstart_d = (state_d == ST_ARM) ? cur_d : mstart_q;
    ctl_d    = ctl_word(PADF, PADL, state_d == ST_HALT, test_d,
                        (state_d == ST_RUN) || (state_d == ST_HALT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cause_q     <= CAUSE_MATCH;
      hdr_q       <= '0;
      diff_q      <= '0;
      start_q     <= '0;
      count_q     <= '0;
      test_q      <= 1'b0;
      cur_q       <= '0;
      ts_q        <= '0;
      res_code_q  <= '0;
      job_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_nonce_q <= '0;
      mstart_q    <= '0;
      ctl_q       <= CTL_IDLE;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      hdr_q       <= hdr_d;
      diff_q      <= diff_d;
      start_q     <= start_d;
      count_q     <= count_d;
      test_q      <= test_d;
      cur_q       <= cur_d;
      ts_q        <= ts_d;
      res_code_q  <= res_code_d;
      job_ready_q <= job_ready_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_nonce_q <= res_nonce_d;
      mstart_q    <= mstart_d;
      ctl_q       <= ctl_d;
    end
  end

  assign job_ready         = job_ready_q;
  assign busy              = busy_q;
  assign res_valid         = res_valid_q;
  assign res_nonce         = res_nonce_q;
  assign res_code          = res_code_q;
  assign miner_header      = hdr_q;
  assign miner_difficulty  = diff_q;
  assign miner_start_nonce = mstart_q;
  assign miner_control     = ctl_q;
endmodule

// File: tb/tb_miner_job_scheduler.sv
// Scoreboarded bench: a sequential-search miner model plus a job driver; results checked by a monitor.
module tb_miner_job_scheduler;
  import miner_pkg::*;

  localparam int TS = 64;
  localparam logic [18:0] CTL_IDLE = {8'h06, 8'h80, 3'b000};

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         job_valid = 1'b0;
  logic         job_ready;
  logic [255:0] job_header = '0;
  logic [255:0] job_difficulty = '0;
  logic [63:0]  job_start_nonce = '0;
  logic [63:0]  job_nonce_count = '0;
  logic         job_test = 1'b0;
  logic         abort = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [63:0]  res_nonce;
  logic [1:0]   res_code;
  logic [255:0] miner_header, miner_difficulty;
  logic [63:0]  miner_start_nonce;
  logic [18:0]  miner_control;
  logic [63:0]  miner_solution = '0;
  logic         miner_irq = 1'b0;
  logic         busy;

  always #5 clk = ~clk;

  miner_job_scheduler #(.TIMESLICE(TS), .SYNC_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_header(job_header),
    .job_difficulty(job_difficulty), .job_start_nonce(job_start_nonce),
    .job_nonce_count(job_nonce_count), .job_test(job_test), .abort(abort),
    .res_valid(res_valid), .res_ready(res_ready), .res_nonce(res_nonce), .res_code(res_code),
    .miner_header(miner_header), .miner_difficulty(miner_difficulty),
    .miner_start_nonce(miner_start_nonce), .miner_control(miner_control),
    .miner_solution(miner_solution), .miner_irq(miner_irq), .busy(busy)
  );

  // Miner model: 2-flop control sync, tests one nonce per cycle, raises irq on a match or on halt.
  logic [1:0]  m_s1 = '0, m_s2 = '0;
  logic        m_active = 1'b0;
  logic [63:0] m_cur = '0;
  logic        m_has = 1'b0;
  logic [63:0] m_nonce = '0;

  always @(posedge clk) begin
    m_s1 <= {miner_control[2], miner_control[0]};
    m_s2 <= m_s1;
    if (!m_s2[0]) begin
      miner_irq <= 1'b0;
      m_active  <= 1'b0;
    end else if (!m_active) begin
      m_active <= 1'b1;
      m_cur    <= miner_start_nonce;
    end else if (!miner_irq) begin
      if (m_s2[1] || (m_has && (m_cur == m_nonce))) begin
        miner_irq      <= 1'b1;
        miner_solution <= m_cur;
      end else begin
        m_cur <= m_cur + 64'd1;
      end
    end
  end

  typedef struct packed {
    logic [1:0]  code;
    logic        exact;
    logic [63:0] start;
    logic [63:0] count;
    logic [63:0] nonce;
    logic [63:0] max_off;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   run_cycles = 0;
  int   resumes = 0;
  logic hold_ready = 1'b0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Result monitor: decides res_ready, then checks anything about to be consumed.
  logic        prev_hold = 1'b0, prev_rv = 1'b0;
  logic [63:0] held_nonce = '0, mon_off;
  logic [1:0]  held_code = '0;
  logic        mon_ok;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
      prev_rv   = 1'b0;
      res_ready = 1'b0;
    end else begin
      res_ready = hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0);
      if (prev_hold) begin
        checks++;
        if (!res_valid || res_nonce !== held_nonce || res_code !== held_code) begin
          failures++;
          $display("FAIL result_stable valid=%0b nonce=%h code=%0d held_nonce=%h held_code=%0d",
                   res_valid, res_nonce, res_code, held_nonce, held_code);
        end
      end
      if (res_valid && !prev_rv) chk("run_low_at_result", 256'(miner_control[0]), 256'(0));
      if (res_valid && res_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result nonce=%h code=%0d", res_nonce, res_code);
        end else begin
          mon_e   = sb_q.pop_front();
          mon_off = res_nonce - mon_e.start;
          mon_ok  = (res_code == mon_e.code) &&
                    (mon_e.exact ? (res_nonce == mon_e.nonce)
                                 : ((mon_off >= mon_e.count) && (mon_off <= mon_e.max_off)));
          if (!mon_ok) begin
            failures++;
            $display("FAIL result code=%0d nonce=%h exp_code=%0d exp_nonce=%h exact=%0b off_range=[%0h,%0h]",
                     res_code, res_nonce, mon_e.code, mon_e.nonce, mon_e.exact, mon_e.count, mon_e.max_off);
          end
        end
        done_cnt++;
      end
      prev_hold  = res_valid && !res_ready;
      held_nonce = res_nonce;
      held_code  = res_code;
      prev_rv    = res_valid;
    end
  end

  // Every resume after a checkpoint must restart at the checkpoint solution.
  logic        ck_pend = 1'b0, prev_run = 1'b0;
  logic [63:0] ck_nonce = '0;

  always @(negedge clk) begin
    if (miner_control[0]) run_cycles++;
    if (!rst_n || res_valid) begin
      ck_pend = 1'b0;
    end else begin
      if (miner_control[0] && !prev_run && ck_pend) begin
        chk("resume_start", 256'(miner_start_nonce), 256'(ck_nonce));
        ck_pend = 1'b0;
        resumes++;
      end
      if (miner_irq && miner_control[2]) begin
        ck_pend  = 1'b1;
        ck_nonce = miner_solution;
      end
    end
    prev_run = miner_control[0];
  end

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic issue_job(input logic [63:0] start, input logic [63:0] count,
                           input logic [255:0] diff, input logic test, input logic has_m,
                           input logic [63:0] m_off, input logic exp_abort);
    exp_t e;
    logic [255:0] hdr;
    e.start   = start;
    e.count   = count;
    e.exact   = 1'b1;
    e.nonce   = start;
    e.max_off = '0;
    if (count == 64'd0) begin
      e.code = RES_EXHAUSTED;
    end else if (exp_abort) begin
      e.code = RES_ABORTED;
    end else if (has_m && (m_off < count)) begin
      e.code  = RES_FOUND;
      e.nonce = start + m_off;
    end else begin
      e.code    = RES_EXHAUSTED;
      e.exact   = 1'b0;
      e.max_off = count + 64'(TS);
      if (has_m && (m_off < e.max_off)) e.max_off = m_off;
    end
    m_has   = has_m;
    m_nonce = start + m_off;
    for (int i = 0; i < 200 && !job_ready; i++) @(negedge clk);
    chk("job_ready_wait", 256'(job_ready), 256'(1));
    hdr = rand256();
    sb_q.push_back(e);
    job_header      = hdr;
    job_difficulty  = diff;
    job_start_nonce = start;
    job_nonce_count = count;
    job_test        = test;
    job_valid       = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    checks++;
    if (miner_header !== hdr || miner_difficulty !== diff || miner_control[1] !== test || busy !== 1'b1) begin
      failures++;
      $display("FAIL job_latch test_bit=%0b exp_test=%0b busy=%0b hdr_ok=%0b diff_ok=%0b",
               miner_control[1], test, busy, miner_header === hdr, miner_difficulty === diff);
    end
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 8000) begin
      @(negedge clk);
      n++;
    end
    chk("job_complete", 256'(done_cnt >= target), 256'(1));
  endtask

  initial begin
    #3000000;
    failures++;
    $display("FAIL global_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int tgt;
    int r0;
    logic [63:0] s;
    logic [63:0] c;
    logic [63:0] mo;
    logic        hm;
    tgt = 0;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_job_ready", 256'(job_ready), 256'(1));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_res_valid", 256'(res_valid), 256'(0));
    chk("rst_control", 256'(miner_control), 256'(CTL_IDLE));
    chk("rst_start_nonce", 256'(miner_start_nonce), 256'(0));
    chk("rst_res_nonce", 256'(res_nonce), 256'(0));
    chk("rst_res_code", 256'(res_code), 256'(0));
    chk("rst_header", miner_header, 256'(0));
    chk("rst_difficulty", miner_difficulty, 256'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // All-ones difficulty: the first nonce tried matches.
    r0 = run_cycles;
    issue_job(64'h100, 64'h40, '1, 1'b0, 1'b1, 64'd0, 1'b0);
    tgt++; wait_done(tgt);
    chk("found_run_seen", 256'(run_cycles > r0), 256'(1));

    // Zero difficulty: several checkpoints then exhaustion.
    r0 = resumes;
    issue_job(64'd0, 64'd100, '0, 1'b0, 1'b0, 64'd0, 1'b0);
    tgt++; wait_done(tgt);
    chk("checkpoint_resumed", 256'(resumes > r0), 256'(1));

    r0 = run_cycles;
    issue_job({$urandom, $urandom}, 64'd0, rand256(), 1'b0, 1'b1, 64'd0, 1'b0);
    tgt++; wait_done(tgt);
    chk("count0_no_run", 256'(run_cycles - r0), 256'(0));

    // Abort while arming.
    issue_job(64'h5000, 64'd1000, '0, 1'b0, 1'b0, 64'd0, 1'b1);
    abort = 1'b1;
    tgt++; wait_done(tgt);
    abort = 1'b0;

    // Abort mid-RUN.
    issue_job(64'h6000, 64'd1000, '0, 1'b0, 1'b0, 64'd0, 1'b1);
    for (int i = 0; i < 400 && !(miner_control[0] && !miner_control[2]); i++) @(negedge clk);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    tgt++; wait_done(tgt);
    abort = 1'b0;

    // Abort during the first HALT.
    issue_job(64'h7000, 64'd1000, '0, 1'b0, 1'b0, 64'd0, 1'b1);
    for (int i = 0; i < 400 && !miner_control[2]; i++) @(negedge clk);
    abort = 1'b1;
    tgt++; wait_done(tgt);
    abort = 1'b0;

    // Abort arriving in the same cycle the scheduler samples a match irq.
    issue_job(64'h8000, 64'd1000, rand256(), 1'b0, 1'b1, 64'd10, 1'b1);
    for (int i = 0; i < 400 && !miner_irq; i++) @(negedge clk);
    abort = 1'b1;
    tgt++; wait_done(tgt);
    abort = 1'b0;

    // Range straddles 2^64 wrap; test bit checked at latch.
    issue_job(64'hFFFF_FFFF_FFFF_FFF0, 64'h20, '0, 1'b1, 1'b0, 64'd0, 1'b0);
    tgt++; wait_done(tgt);

    for (int j = 0; j < 8; j++) begin
      s  = {$urandom, $urandom};
      c  = 64'($urandom_range(1, 300));
      hm = ($urandom_range(0, 3) != 0);
      mo = 64'($urandom_range(0, 400));
      issue_job(s, c, rand256(), 1'($urandom_range(0, 1)), hm, mo, 1'b0);
      tgt++; wait_done(tgt);
    end

    // Reset in the middle of RUN drops everything immediately.
    issue_job(64'h9000, 64'd1000, '0, 1'b1, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 400 && !miner_control[0]; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_job_ready", 256'(job_ready), 256'(1));
    chk("midrst_busy", 256'(busy), 256'(0));
    chk("midrst_res_valid", 256'(res_valid), 256'(0));
    chk("midrst_control", 256'(miner_control), 256'(CTL_IDLE));
    sb_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Next job completes normally while the host stalls res_ready.
    hold_ready = 1'b1;
    issue_job(64'hA000, 64'd200, rand256(), 1'b0, 1'b1, 64'd150, 1'b0);
    for (int i = 0; i < 2000 && !res_valid; i++) @(negedge clk);
    chk("held_result_valid", 256'(res_valid), 256'(1));
    repeat (8) @(negedge clk);
    hold_ready = 1'b0;
    tgt = done_cnt + 1;
    wait_done(tgt);

    chk("scoreboard_empty", 256'(sb_q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
